// File: rtl/blockstacker_pkg.sv
// Shared constants and types for the block-stacker game datapath.
// Screen geometry, block size, erase colour and the plotter state encoding.
package blockstacker_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BLOCK_W  = 4;
  localparam int BLOCK_H  = 4;

  localparam logic [2:0] COLOUR_ERASE = 3'b000;

  // Counter widths: px spans up to 7*BLOCK_W-1, py spans BLOCK_H-1.
  localparam int PX_W = 5;
  localparam int PY_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } plotter_state_t;

endpackage

// File: rtl/block_plotter_pixel_scan.sv
// Nested pixel counter for one block row: px runs across len*BLOCK_W columns,
// py steps down BLOCK_H rows; last flags the final pixel of the row.
module pixel_scan
  import blockstacker_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [2:0]      len,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            last
);

  logic [PX_W-1:0] width_m1;
  logic            px_wrap;

  // len==0 never enables the counter, so the underflow here is harmless.
  assign width_m1 = PX_W'(int'(len) * BLOCK_W) - PX_W'(1);
  assign px_wrap  = (px == width_m1);
  assign last     = px_wrap && (py == PY_W'(BLOCK_H - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      px <= '0;
      py <= '0;
    end else if (clear) begin
      px <= '0;
      py <= '0;
    end else if (enable) begin
      if (px_wrap) begin
        px <= '0;
        py <= py + PY_W'(1);
      end else begin
        px <= px + PX_W'(1);
      end
    end
  end

endmodule

// File: rtl/block_plotter.sv
// Streams one pixel per clock of a row of len blocks to the VGA adapter plot port,
// clipping anything that falls off the 160x120 screen.
module block_plotter
  import blockstacker_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic [2:0] len_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  plotter_state_t  state;
  logic [7:0]      x0;
  logic [6:0]      y0;
  logic [2:0]      colour_q;
  logic [2:0]      len_q;

  logic [PX_W-1:0] px;
  logic [PY_W-1:0] py;
  logic            last;
  logic            accept;
  logic            drawing;

  logic [8:0]      sum_x;
  logic [7:0]      sum_y;
  logic            on_screen;

  assign accept  = (state == IDLE) && start;
  assign drawing = (state == DRAW);

  pixel_scan u_scan (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (drawing),
    .len    (len_q),
    .px     (px),
    .py     (py),
    .last   (last)
  );

  // Sums are kept one bit wider than the screen coordinates so off-screen pixels never wrap to x=0.
  assign sum_x     = {1'b0, x0} + 9'(px);
  assign sum_y     = {1'b0, y0} + 8'(py);
  assign on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      x0       <= '0;
      y0       <= '0;
      colour_q <= COLOUR_ERASE;
      len_q    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x0       <= x_in;
          y0       <= y_in;
          colour_q <= colour_in;
          len_q    <= len_in;
          state    <= (len_in == 3'd0) ? DONE : DRAW;
        end
        DRAW: if (last) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage lags the state by one edge, so busy/plot line up with the pixel they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= COLOUR_ERASE;
    end else begin
      busy <= drawing;
      done <= (state == DONE);
      plot <= drawing && on_screen;
      if (drawing) begin
        vga_x      <= sum_x[7:0];
        vga_y      <= sum_y[6:0];
        vga_colour <= colour_q;
      end
    end
  end

endmodule

// File: tb/tb_block_plotter.sv
// Directed bench for block_plotter: each pixel is checked against a small
// raster model, plus reset, clipping, erase, len 0 and ignored-start cases.
module tb_block_plotter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [2:0] len_in;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  block_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .len_in     (len_in),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Accepts one request at edge 0 and checks edges 1..N+2 against the raster model.
  // poke>0 pulses start with different inputs after edge 'poke'; it must be ignored.
  task automatic run_op(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        input logic [2:0] l, input int poke, output int plots, output int wrapped);
    int n;
    int wdt;
    int ex;
    int ey;
    logic exp_plot;
    n       = int'(l) * 16;
    wdt     = int'(l) * 4;
    plots   = 0;
    wrapped = 0;
    @(negedge clk);
    x_in = x; y_in = y; colour_in = c; len_in = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      @(posedge clk); #1;
      if (k == poke) begin
        start = 1'b1; x_in = ~x; y_in = ~y; colour_in = ~c; len_in = 3'd7;
      end else begin
        start = 1'b0;
      end
      if (k <= n) begin
        ex       = int'(x) + (k - 1) % wdt;
        ey       = int'(y) + (k - 1) / wdt;
        exp_plot = (ex < 160) && (ey < 120);
        check("busy_draw", busy, 1);
        check("done_draw", done, 0);
        check("plot", plot, exp_plot);
        if (exp_plot) begin
          check("vga_x", vga_x, ex % 256);
          check("vga_y", vga_y, ey % 128);
          check("vga_colour", vga_colour, c);
        end
        if (plot === 1'b1) begin
          plots++;
          if (vga_x < x) wrapped++;
        end
      end else if (k == n + 1) begin
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("plot_done", plot, 0);
      end else begin
        check("done_clear", done, 0);
      end
    end
  endtask

  initial begin
    int plots;
    int wrapped;
    int stray;

    reset = 1'b0; start = 1'b0;
    x_in = '0; y_in = '0; colour_in = '0; len_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", plot, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single block fully on screen.
    run_op(8'd8, 7'd116, 3'b010, 3'd1, 0, plots, wrapped);
    check("single_plots", plots, 16);

    // Row of 3 ending exactly at column 159.
    run_op(8'd148, 7'd0, 3'b111, 3'd3, 0, plots, wrapped);
    check("row148_plots", plots, 48);

    // Row of 3 with the last block off the right edge.
    run_op(8'd152, 7'd10, 3'b001, 3'd3, 0, plots, wrapped);
    check("row152_plots", plots, 32);

    // Right and bottom clip together; no writes may wrap to x=0..3.
    run_op(8'd156, 7'd118, 3'b100, 3'd2, 0, plots, wrapped);
    check("corner_plots", plots, 8);
    check("corner_wrap", wrapped, 0);

    // Erase.
    run_op(8'd40, 7'd60, 3'b000, 3'd2, 0, plots, wrapped);
    check("erase_plots", plots, 32);

    // Zero length: done one edge after acceptance, no pixels.
    run_op(8'd40, 7'd60, 3'b011, 3'd0, 0, plots, wrapped);
    check("len0_plots", plots, 0);

    // Start mid-draw with different inputs is ignored.
    run_op(8'd20, 7'd40, 3'b101, 3'd1, 5, plots, wrapped);
    check("poke_plots", plots, 16);
    repeat (3) @(posedge clk);
    #1;
    check("poke_no_requeue", busy, 0);

    // Reset mid-draw aborts with no done pulse afterwards.
    @(negedge clk);
    x_in = 8'd0; y_in = 7'd0; colour_in = 3'b111; len_in = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_plot", plot, 0);
    check("abort_vga_x", vga_x, 0);
    check("abort_vga_y", vga_y, 0);
    reset = 1'b1;
    stray = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0) stray++;
    end
    check("abort_quiet", stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
